mio_bus_arb: RTL



---
 rtl/mio_pkg.sv | 8 +
 rtl/mio_bus_arb_rr_arb2.sv | 17 +
 rtl/mio_bus_arb.sv | 102 ++++++++++
 3 files changed

// File: rtl/mio_pkg.sv
// mio_pkg: shared types and constants for the memory/IO bus controller.
package mio_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  localparam logic [3:0] IO_REGION_DEF = 4'hF;
  localparam logic [31:0] DEAD_DATA = 32'hDEAD_BEEF;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DEV = 1'b1;
endpackage

// File: rtl/mio_bus_arb_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; grant 0 = CPU, 1 = secondary.
module rr_arb2
  import mio_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic       grant
);
  logic last;
  // On a collision the requester not served last wins; a lone requester always wins.
  assign grant = &req ? ~last : req[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= OWN_DEV;
    else if (en) last <= grant;
endmodule

// File: rtl/mio_bus_arb.sv
// mio_bus_arb: CPU/secondary bus controller with RAM wait states and IO handshake.
// Define MIO_TIMEOUT_EN to abort stalled IO accesses with DEAD_DATA and a bus_err pulse.
module mio_bus_arb
  import mio_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter logic [3:0] IO_REGION = IO_REGION_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dev_req,
  input  logic [31:0] dev_addr,
  output logic [31:0] dev_rdata,
  output logic        dev_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] io_addr,
  output logic        io_we,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ready,
  output logic        bus_err,
  output logic        owner
);
  localparam int CW = $clog2(RAM_WAIT > TIMEOUT ? RAM_WAIT : TIMEOUT) + 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q, fin_data, sel_addr;
  logic we_q, io_q, err_q, grant, grant_en, tmo, fin, in_acc;
  rr_arb2 u_arb (
    .clk(clk),
    .reset(reset),
    .req({dev_req, cpu_req}),
    .en(grant_en),
    .grant(grant)
  );
  assign grant_en = state == IDLE && (cpu_req || dev_req);
  assign sel_addr = grant ? dev_addr : cpu_addr;
  assign in_acc = state == ACC;
`ifdef MIO_TIMEOUT_EN
  assign tmo = io_q && !io_ready && cnt == CW'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  assign fin = io_q ? (io_ready || tmo) : cnt == CW'(RAM_WAIT - 1);
  assign fin_data = tmo ? DEAD_DATA : io_q ? io_rdata : mem_rdata;
  assign mem_addr = in_acc && !io_q ? addr_q : '0;
  assign mem_we = in_acc && !io_q && we_q && cnt == '0;
  assign mem_wdata = wdata_q;
  assign io_addr = in_acc && io_q ? addr_q : '0;
  assign io_we = in_acc && io_q && we_q;
  assign io_wdata = wdata_q;
  assign bus_err = err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      owner <= OWN_CPU;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      io_q <= 1'b0;
      cpu_rdata <= '0;
      dev_rdata <= '0;
      cpu_ready <= 1'b0;
      dev_ready <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      dev_ready <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: if (grant_en) begin
          state <= ACC;
          cnt <= '0;
          owner <= grant;
          addr_q <= sel_addr;
          wdata_q <= cpu_wdata;
          we_q <= !grant && cpu_we;
          io_q <= sel_addr[31:28] == IO_REGION;
        end
        ACC: if (fin) begin
          state <= DONE;
          err_q <= tmo;
          cpu_ready <= owner == OWN_CPU;
          dev_ready <= owner == OWN_DEV;
          if (owner == OWN_CPU) cpu_rdata <= fin_data;
          else dev_rdata <= fin_data;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
